// File: rtl/memy_pkg.sv
// Shared definitions for the memory-Y DMA block: word/address width, memory
// depth, FSM state encoding and the range check applied to every request.
package memy_pkg;

  localparam int W = 16;
  localparam int M = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // True when base..base+count-1 lies inside memory-Y. The sum is computed one
  // bit wider so an overflow of the W-bit address space is caught.
  function automatic logic range_ok(input logic [W-1:0] base, input logic [W-1:0] count);
    logic [W:0] span;
    span = {1'b0, base} + {1'b0, count};
    return span <= (W+1)'(M);
  endfunction

endpackage

// File: rtl/memy_dma_if.sv
// RAM-side bus of the memory-Y DMA: port X is the read port, port Y the write
// port of the dual-port RAM. The DMA is the master, the RAM the slave.
interface memy_dma_if
  import memy_pkg::*;
();

  logic [W-1:0] addr_x;
  logic         we_x;
  logic [W-1:0] data_x;
  logic [W-1:0] q_x;
  logic [W-1:0] addr_y;
  logic         we_y;
  logic [W-1:0] data_y;

  modport master (
    output addr_x, we_x, data_x,
    input  q_x,
    output addr_y, we_y, data_y
  );

  modport slave (
    input  addr_x, we_x, data_x,
    output q_x,
    input  addr_y, we_y, data_y
  );

endinterface

// File: rtl/memy_dma_agu.sv
// Address generator for the memory-Y DMA. Holds the read and write address
// counters, the copy direction and the one-cycle read-to-write pipeline
// (write enable + write address). In fill mode the pipeline register itself
// walks the destination range, since there is no read to wait for.
module memy_dma_agu
  import memy_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         fill_req,
  input  logic         fill_mode,
  input  logic         issue,
  input  logic         more,
  input  logic [W-1:0] src,
  input  logic [W-1:0] dst,
  input  logic [W-1:0] len,
  output logic [W-1:0] addr_x,
  output logic [W-1:0] addr_y,
  output logic         we_y
);

  logic         desc;
  logic         desc_q;
  logic [W:0]   src_end;
  logic [W-1:0] wr_addr;

  // Copy downwards only when the destination starts inside the source range
  // above src, so every source word is read before it is overwritten.
  always_comb begin
    src_end = {1'b0, src} + {1'b0, len};
    desc    = !fill_req && (dst > src) && ({1'b0, dst} < src_end);
  end

  // Counters advance once per issued word; they stop on the last word so the
  // read address never steps outside the requested range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_x  <= '0;
      wr_addr <= '0;
      desc_q  <= 1'b0;
      we_y    <= 1'b0;
      addr_y  <= '0;
    end else if (load) begin
      desc_q <= desc;
      if (fill_req) begin
        we_y   <= 1'b1;
        addr_y <= dst;
      end else begin
        addr_x  <= desc ? src + len - W'(1) : src;
        wr_addr <= desc ? dst + len - W'(1) : dst;
        we_y    <= 1'b0;
      end
    end else begin
      we_y <= issue;
      if (issue) begin
        if (fill_mode) begin
          addr_y <= addr_y + W'(1);
        end else begin
          addr_y <= wr_addr;
          if (more) begin
            addr_x  <= desc_q ? addr_x - W'(1) : addr_x + W'(1);
            wr_addr <= desc_q ? wr_addr - W'(1) : wr_addr + W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/memy_dma.sv
// Memory-Y block-copy engine: copies len words from src to dst at one word
// per cycle, handling overlapping ranges by picking the copy direction.
// Optional MEMY_DMA_FILL_EN adds fill/fill_val to write a constant instead.
module memy_dma
  import memy_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] src,
  input  logic [W-1:0] dst,
  input  logic [W-1:0] len,
`ifdef MEMY_DMA_FILL_EN
  input  logic         fill,
  input  logic [W-1:0] fill_val,
`endif
  output logic         busy,
  output logic         done,
  output logic         err,
  memy_dma_if.master   ram
);

  state_t       state;
  logic [W-1:0] left;
  logic         req_fill;
  logic         req_ok;
  logic         len_zero;
  logic         load;
  logic         issue;
  logic         more;
`ifdef MEMY_DMA_FILL_EN
  logic         fill_q;
  logic [W-1:0] fill_val_q;
`endif

  // Request decode: a fill never touches port X, so src is not checked then.
  always_comb begin
    req_fill = 1'b0;
`ifdef MEMY_DMA_FILL_EN
    req_fill = fill;
`endif
    len_zero = (len == '0);
    req_ok   = range_ok(dst, len) && (req_fill || range_ok(src, len));
    load     = (state == IDLE) && start && req_ok && !len_zero;
    issue    = (state == RUN) && (left != '0);
    more     = (left > W'(1));
  end

  // Control FSM; left counts words still to be issued. A copy needs one extra
  // RUN cycle to drain the last read into its write, a fill does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      left  <= '0;
`ifdef MEMY_DMA_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!req_ok) begin
              err <= 1'b1;
            end else if (len_zero) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              left  <= req_fill ? len - W'(1) : len;
`ifdef MEMY_DMA_FILL_EN
              fill_q     <= fill;
              fill_val_q <= fill_val;
`endif
            end
          end
        end
        RUN: begin
          if (left != '0) begin
            left <= left - W'(1);
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  memy_dma_agu u_agu (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
`ifdef MEMY_DMA_FILL_EN
    .fill_req  (fill),
    .fill_mode (fill_q),
`else
    .fill_req  (1'b0),
    .fill_mode (1'b0),
`endif
    .issue     (issue),
    .more      (more),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .addr_x    (ram.addr_x),
    .addr_y    (ram.addr_y),
    .we_y      (ram.we_y)
  );

  assign ram.we_x   = 1'b0;
  assign ram.data_x = '0;

  // Write data comes straight from the RAM read port, whose output is already
  // the registered word read one cycle earlier; it is held at 0 when idle.
`ifdef MEMY_DMA_FILL_EN
  assign ram.data_y = !ram.we_y ? '0 : (fill_q ? fill_val_q : ram.q_x);
`else
  assign ram.data_y = ram.we_y ? ram.q_x : '0;
`endif

endmodule

// File: doc/memy_dma.md
Name: memy_dma

Overview:
- Block-copy engine sitting directly upstream of the memory-Y dual-port RAM. It owns both RAM ports: port X for reads, port Y for writes.
- Given a start pulse with src, dst and len, it copies len words from src..src+len-1 to dst..dst+len-1 at one word per cycle.
- Handles overlapping ranges, and signals busy, done and err to the CPU control path.

Parameters:
- W, 16, data and address width; matches the RAM word and address width.
- M, 256, memory-Y depth in words; the legal address range is 0..M-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- src  in  W  source base address; sampled with start.
- dst  in  W  destination base address; sampled with start.
- len  in  W  word count; sampled with start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes, including len=0.
- err  out  1  one-cycle pulse when a request is rejected.
- addr_x  out  W  RAM port-X (read) address.
- we_x  out  1  RAM port-X write enable; always driven 0, never Z.
- data_x  out  W  RAM port-X write data; always driven 0.
- q_x  in  W  RAM port-X read data; valid one cycle after addr_x is presented.
- addr_y  out  W  RAM port-Y (write) address.
- we_y  out  1  RAM port-Y write enable; always driven 0 or 1, never Z.
- data_y  out  W  RAM port-Y write data.

Behaviour:
- Reset (asynchronous): state=IDLE. busy, done, err, we_x, we_y = 0. addr_x, addr_y, data_x, data_y = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, range check:
  - src+len > M or dst+len > M (computed at W+1 bits) -> err pulse next cycle; no RAM access; stay IDLE.
  - len=0 -> go to DONE; no RAM access.
  - otherwise -> RUN; busy=1 from the next cycle.
- Direction, fixed at start: descending if dst > src and dst < src+len; otherwise ascending (including dst == src).
- RUN read issue: on cycle i (i = 0..len-1), addr_x = src+i (ascending) or src+len-1-i (descending).
- RUN write, one cycle after each read: we_y=1, addr_y = matching dst offset, data_y = q_x.
  - Total RUN length is len+1 cycles: the last cycle issues only the final write.
- Overlap safety: with this ordering and the RAM's read-old-on-same-edge behaviour, no read ever returns an already-overwritten word.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy or in DONE: ignored; no err.
- Reset mid-RUN: aborts immediately; words already written stay written; no done pulse.
- Address counters are W bits. Wrap-around cannot occur because the range check rejects it first.
- Throughput: one word per cycle. Latency from start to done is len+2 cycles for len>0.

Optional Feature:
- Macro: MEMY_DMA_FILL_EN.
- With the macro defined, the block gains two inputs:
  - fill  in  1  sampled with start.
  - fill_val  in  W  sampled with start.
- When fill=1:
  - No port-X reads are issued; src is ignored and not range-checked.
  - Writes fill_val to dst..dst+len-1, ascending, one word per cycle.
  - RUN lasts len cycles.
- Without the macro: the fill and fill_val ports do not exist and the block is copy-only.

Decomposition:
- Shared package memy_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the W and M constants, mirroring params.vh;
  - a range-check function returning a legal flag for base+len versus M.
- One natural sub-module: memy_dma_agu.
  - Holds the read/write address counters, the direction flag and the one-cycle read-to-write pipeline register (valid + write address).
  - The FSM stays in the top module.

Test Plan:
- Basic copy: RAM preloaded with mem[i]=i+100; start with src=10, dst=50, len=4 -> at cycles 2..5 we_y=1, addr_y=50..53, data_y=110..113; done at cycle 6; mem[50..53]=110..113.
- Overlap, forward shift: mem[i]=i; src=20, dst=22, len=5 -> descending order, addr_y=26,25,24,23,22; final mem[22..26]=20..24.
- Overlap, backward shift: mem[i]=i; src=22, dst=20, len=5 -> ascending order; final mem[20..24]=22..26.
- Range error: src=250, dst=0, len=10 with M=256 -> err=1 for one cycle, we_y never asserted, busy stays 0.
- len=0 and busy-start: len=0 -> done pulse with no writes. A second start during RUN is ignored and done fires exactly once.
- Mid-transfer reset: assert rst during RUN at word 2 of len=8 -> all outputs 0 immediately, no done pulse, mem[dst..dst+1] updated and mem[dst+3..] unchanged.
- With MEMY_DMA_FILL_EN: fill=1, fill_val=16'hA5A5, dst=5, len=3 -> mem[5..7]=A5A5, we_x=0 and no reads throughout, done 4 cycles after start.
